// File: rtl/flash_cmd_seq.sv
// flash_cmd_seq: expands one flash request into the SPI engine's primitive sequence (WREN, op, RDSR1 polling).
// Optional bounded polling with error reporting: define FLASH_SEQ_TIMEOUT_EN.
module flash_cmd_seq #(
   parameter logic [19:0] POLL_MAX = 20'd1000000
) (
   input  logic        clock25M,
   input  logic        flash_rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [23:0] addr,
   output logic [3:0]  cmd_type,
   output logic [7:0]  flash_cmd,
   output logic [23:0] flash_addr,
   input  logic        Done_Sig,
   input  logic [7:0]  mydata_o,
   input  logic        myvalid_o,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  status_o,
   output logic [15:0] id_data,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic [7:0]  rd_index
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      POLL_ISSUE,
      POLL_WAIT,
      FIN
   } state_t;

   typedef enum logic [2:0] {
      PRIM_RDID  = 3'b000,
      PRIM_WREN  = 3'b001,
      PRIM_ERASE = 3'b010,
      PRIM_RDSR1 = 3'b011,
      PRIM_PROG  = 3'b101,
      PRIM_READ  = 3'b110
   } prim_t;

   typedef enum logic [1:0] {
      OP_RDID  = 2'b00,
      OP_ERASE = 2'b01,
      OP_PROG  = 2'b10,
      OP_READ  = 2'b11
   } op_t;

   if (POLL_MAX == 20'd0) begin : g_poll_max_check
      $error("flash_cmd_seq: POLL_MAX must be nonzero");
   end

   function automatic prim_t first_prim(input op_t o);
      case (o)
         OP_RDID: first_prim = PRIM_RDID;
         OP_READ: first_prim = PRIM_READ;
         default: first_prim = PRIM_WREN;
      endcase
   endfunction

   function automatic prim_t second_prim(input op_t o);
      second_prim = (o == OP_ERASE) ? PRIM_ERASE : PRIM_PROG;
   endfunction

   function automatic logic [7:0] opcode_of(input prim_t p);
      case (p)
         PRIM_WREN:  opcode_of = 8'h06;
         PRIM_RDSR1: opcode_of = 8'h05;
         PRIM_ERASE: opcode_of = 8'h20;
         PRIM_PROG:  opcode_of = 8'h02;
         PRIM_READ:  opcode_of = 8'h03;
         default:    opcode_of = 8'h90;
      endcase
   endfunction

   // WREN and RDSR1 carry no address; everything else forwards the latched one.
   function automatic logic prim_uses_addr(input prim_t p);
      prim_uses_addr = (p != PRIM_WREN) && (p != PRIM_RDSR1);
   endfunction

   state_t      state_q, state_d;
   op_t         op_q, op_d;
   logic [23:0] addr_q, addr_d;
   logic        step_q, step_d;
   logic [3:0]  cmd_type_q, cmd_type_d;
   logic [7:0]  flash_cmd_q, flash_cmd_d;
   logic [23:0] flash_addr_q, flash_addr_d;
   logic [7:0]  status_q, status_d;
   logic [15:0] id_data_q, id_data_d;
   logic [1:0]  id_cnt_q, id_cnt_d;
   logic [7:0]  rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic [7:0]  rd_index_q, rd_index_d;

   logic        issue;
   prim_t       issue_prim;
   logic [23:0] issue_addr;
   logic        finish;
   logic        repoll;
   logic        dev_busy;
   logic        is_write_op;

`ifdef FLASH_SEQ_TIMEOUT_EN
   logic        error_q, error_d;
   logic [19:0] poll_cnt_q, poll_cnt_d;
`endif

   assign is_write_op = (op_q == OP_ERASE) || (op_q == OP_PROG);
   // A status byte arriving together with Done_Sig is the one that decides.
   assign dev_busy    = myvalid_o ? mydata_o[0] : status_q[0];

   // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_d       = addr_q;
      step_d       = step_q;
      cmd_type_d   = cmd_type_q;
      flash_cmd_d  = flash_cmd_q;
      flash_addr_d = flash_addr_q;
      status_d     = status_q;
      id_data_d    = id_data_q;
      id_cnt_d     = id_cnt_q;
      rd_data_d    = rd_data_q;
      rd_valid_d   = 1'b0;
      rd_index_d   = rd_index_q + {7'd0, rd_valid_q};
      issue        = 1'b0;
      issue_prim   = PRIM_RDID;
      issue_addr   = addr_q;
      finish       = 1'b0;
      repoll       = 1'b0;
`ifdef FLASH_SEQ_TIMEOUT_EN
      error_d      = error_q;
      poll_cnt_d   = poll_cnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               op_d       = op_t'(op);
               addr_d     = addr;
               step_d     = 1'b0;
               id_cnt_d   = 2'd0;
               rd_index_d = 8'd0;
               issue      = 1'b1;
               issue_prim = first_prim(op_t'(op));
               issue_addr = addr;
               state_d    = ISSUE;
`ifdef FLASH_SEQ_TIMEOUT_EN
               error_d    = 1'b0;
               poll_cnt_d = 20'd0;
`endif
            end
         end

         ISSUE: begin
            cmd_type_d = {1'b0, cmd_type_q[2:0]};
            state_d    = WAIT;
         end

         WAIT: begin
            if (myvalid_o && (op_q == OP_RDID) && (id_cnt_q != 2'd2)) begin
               if (id_cnt_q == 2'd0) id_data_d[15:8] = mydata_o;
               else                  id_data_d[7:0]  = mydata_o;
               id_cnt_d = id_cnt_q + 2'd1;
            end
            if (myvalid_o && (op_q == OP_READ)) begin
               rd_data_d  = mydata_o;
               rd_valid_d = 1'b1;
            end
            if (Done_Sig) begin
               if (is_write_op && !step_q) begin
                  step_d     = 1'b1;
                  issue      = 1'b1;
                  issue_prim = second_prim(op_q);
                  state_d    = ISSUE;
               end else if (is_write_op) begin
                  repoll = 1'b1;
               end else begin
                  finish = 1'b1;
               end
            end
         end

         POLL_ISSUE: begin
            cmd_type_d = {1'b0, cmd_type_q[2:0]};
            state_d    = POLL_WAIT;
         end

         POLL_WAIT: begin
            if (myvalid_o) status_d = mydata_o;
            if (Done_Sig) begin
               if (!dev_busy) begin
                  finish = 1'b1;
               end else begin
`ifdef FLASH_SEQ_TIMEOUT_EN
                  if (poll_cnt_q >= POLL_MAX) begin
                     finish  = 1'b1;
                     error_d = 1'b1;
                  end else begin
                     repoll = 1'b1;
                  end
`else
                  repoll = 1'b1;
`endif
               end
            end
         end

         FIN: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (repoll) begin
         state_d    = POLL_ISSUE;
         issue      = 1'b1;
         issue_prim = PRIM_RDSR1;
`ifdef FLASH_SEQ_TIMEOUT_EN
         poll_cnt_d = poll_cnt_q + 20'd1;
`endif
      end

      if (issue) begin
         cmd_type_d   = {1'b1, issue_prim};
         flash_cmd_d  = opcode_of(issue_prim);
         flash_addr_d = prim_uses_addr(issue_prim) ? issue_addr : 24'd0;
      end

      if (finish) begin
         state_d      = FIN;
         cmd_type_d   = 4'd0;
         flash_cmd_d  = 8'd0;
         flash_addr_d = 24'd0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
   always_ff @(posedge clock25M or posedge flash_rst) begin
      if (flash_rst) begin
         state_q      <= IDLE;
         op_q         <= OP_RDID;
         addr_q       <= 24'd0;
         step_q       <= 1'b0;
         cmd_type_q   <= 4'd0;
         flash_cmd_q  <= 8'd0;
         flash_addr_q <= 24'd0;
         status_q     <= 8'd0;
         id_data_q    <= 16'd0;
         id_cnt_q     <= 2'd0;
         rd_data_q    <= 8'd0;
         rd_valid_q   <= 1'b0;
         rd_index_q   <= 8'd0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         step_q       <= step_d;
         cmd_type_q   <= cmd_type_d;
         flash_cmd_q  <= flash_cmd_d;
         flash_addr_q <= flash_addr_d;
         status_q     <= status_d;
         id_data_q    <= id_data_d;
         id_cnt_q     <= id_cnt_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
         rd_index_q   <= rd_index_d;
      end
   end

`ifdef FLASH_SEQ_TIMEOUT_EN
   always_ff @(posedge clock25M or posedge flash_rst) begin
      if (flash_rst) begin
         error_q    <= 1'b0;
         poll_cnt_q <= 20'd0;
      end else begin
         error_q    <= error_d;
         poll_cnt_q <= poll_cnt_d;
      end
   end

   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   assign cmd_type   = cmd_type_q;
   assign flash_cmd  = flash_cmd_q;
   assign flash_addr = flash_addr_q;
   assign busy       = (state_q == ISSUE) || (state_q == WAIT) ||
                       (state_q == POLL_ISSUE) || (state_q == POLL_WAIT);
   assign done       = (state_q == FIN);
   assign status_o   = status_q;
   assign id_data    = id_data_q;
   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign rd_index   = rd_index_q;

endmodule
